// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // True for every opcode that has a dedicated execution path.
  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUop plus instruction function fields to an ALU control code.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] ALUop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ALUctrl
);

  // Purely combinational decode; every path assigns ALUctrl.
  always_comb begin
    ALUctrl = ALU_ADD;
    case (ALUop)
      ALUOP_ADD: ALUctrl = ALU_ADD;
      ALUOP_SUB: ALUctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUctrl = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUctrl = ALU_SLT;
          3'b110:  ALUctrl = ALU_OR;
          3'b111:  ALUctrl = ALU_AND;
          default: ALUctrl = ALU_ADD;
        endcase
      end
      default: ALUctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer driving a shared ALU and a handshaked memory port.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        EQ,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUsrcA,
  output logic [1:0]  ALUsrcB,
  output logic [2:0]  ALUctrl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ResultSrc,
  output logic        Retire
);

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [1:0] aluop;
  logic       unused_instr;

  assign opcode       = Instr[6:0];
  assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

  alu_decoder u_alu_decoder (
    .ALUop    (aluop),
    .funct3   (Instr[14:12]),
    .funct7b5 (Instr[30]),
    .op5      (Instr[5]),
    .ALUctrl  (ALUctrl)
  );

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state sequencing; memory states wait for MemReady.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; reset forces enables low and selects to their FETCH values.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    Retire    = 1'b0;
    ALUsrcA   = SRCA_PC;
    ALUsrcB   = SRCB_REG;
    aluop     = ALUOP_ADD;
    ImmSrc    = IMM_I;
    ResultSrc = RES_ALUOUT;
    if (rst) begin
      ALUsrcB   = SRCB_FOUR;
      ResultSrc = RES_ALURESULT;
    end else begin
      case (state_q)
        S_FETCH: begin
          MemReq    = 1'b1;
          ALUsrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          IRWrite   = MemReady;
          PCWrite   = MemReady;
        end
        S_DECODE: begin
          ALUsrcA = SRCA_OLDPC;
          ALUsrcB = SRCB_IMM;
          case (opcode)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            default: ImmSrc = IMM_I;
          endcase
          Retire = !is_supported(opcode);
        end
        S_MEMADR: begin
          ALUsrcA = SRCA_REG;
          ALUsrcB = SRCB_IMM;
          ImmSrc  = (opcode == OP_SW) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
          Retire    = 1'b1;
        end
        S_MEMWRITE: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
          Retire   = MemReady;
        end
        S_EXECUTER: begin
          ALUsrcA = SRCA_REG;
          ALUsrcB = SRCB_REG;
          aluop   = ALUOP_FUNCT;
        end
        S_EXECUTEI: begin
          ALUsrcA = SRCA_REG;
          ALUsrcB = SRCB_IMM;
          aluop   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          Retire   = 1'b1;
        end
        S_BEQ: begin
          ALUsrcA = SRCA_REG;
          ALUsrcB = SRCB_REG;
          aluop   = ALUOP_SUB;
          PCWrite = EQ;
          Retire  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RISC-V datapath. It replaces the single-cycle decoder with a state machine that steps one shared ALU and one shared instruction/data memory port through fetch, decode, execute, memory and writeback. Memory accesses use a request/ready handshake, so the memory may take any number of cycles. It supports lw, sw, R-type (add, sub, and, or, slt), addi and beq. Any other opcode retires as a no-op.

## Interface
Parameters:
- none. Encodings are fixed in `ctrl_pkg`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `Instr`  in  32  instruction register contents (valid from DECODE onward)
- `EQ`  in  1  ALU zero flag; meaningful in BEQ state
- `MemReady`  in  1  memory has completed the current request this cycle
- `MemReq`  out  1  memory access request, held until `MemReady`
- `MemWrite`  out  1  qualifies `MemReq` as a store
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `IRWrite`  out  1  load instruction register
- `PCWrite`  out  1  load PC
- `RegWrite`  out  1  register file write enable
- `ALUsrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RegA
- `ALUsrcB`  out  2  ALU B select: 00 = RegB, 01 = Imm, 10 = constant 4
- `ALUctrl`  out  3  ALU operation (encodings below)
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B
- `ResultSrc`  out  2  Result bus select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `Retire`  out  1  one-cycle pulse on the last cycle of every instruction

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ.

- **FETCH**
  - Outputs: `MemReq=1`, `AdrSrc=0`, `ALUsrcA=00`, `ALUsrcB=10`, ALU add, `ResultSrc=10`.
  - While `MemReady=0`: stay; `IRWrite=0`, `PCWrite=0`.
  - When `MemReady=1`: `IRWrite=1`, `PCWrite=1`, go to DECODE.
- **DECODE**
  - Outputs: `ALUsrcA=01`, `ALUsrcB=01`, ALU add (computes branch target into ALUOut). `ImmSrc` is decoded from the opcode.
  - Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 (R-type) → EXECUTER
    - 0010011 (addi) → EXECUTEI
    - 1100011 (beq) → BEQ
    - anything else → FETCH, with `Retire=1`
- **MEMADR**
  - Outputs: `ALUsrcA=10`, `ALUsrcB=01`, ALU add. `ImmSrc` = I for lw, S for sw.
  - Next: lw → MEMREAD; sw → MEMWRITE.
- **MEMREAD**
  - Outputs: `MemReq=1`, `AdrSrc=1`, `ResultSrc=00`.
  - Stays until `MemReady=1`, then → MEMWB.
- **MEMWB**
  - Outputs: `ResultSrc=01`, `RegWrite=1`, `Retire=1`.
  - Next: FETCH.
- **MEMWRITE**
  - Outputs: `MemReq=1`, `MemWrite=1`, `AdrSrc=1`.
  - Stays until `MemReady=1`; on that cycle `Retire=1` and → FETCH.
- **EXECUTER**
  - Outputs: `ALUsrcA=10`, `ALUsrcB=00`, ALUop = funct.
  - Next: ALUWB.
- **EXECUTEI**
  - Outputs: `ALUsrcA=10`, `ALUsrcB=01`, ALUop = funct, `ImmSrc=00`.
  - Next: ALUWB.
- **ALUWB**
  - Outputs: `ResultSrc=00`, `RegWrite=1`, `Retire=1`.
  - Next: FETCH.
- **BEQ**
  - Outputs: `ALUsrcA=10`, `ALUsrcB=00`, ALU sub, `ResultSrc=00`, `PCWrite=EQ`, `Retire=1`.
  - Next: FETCH.

ALU decode (sub-module):
- ALUop 00 → 000 add.
- ALUop 01 → 001 sub.
- ALUop 10 (funct), by funct3:
  - 000 → 001 sub if `funct7b5 & op5`, else 000 add
  - 010 → 101 slt
  - 110 → 011 or
  - 111 → 010 and
  - any other funct3 → 000 add. The decoder is fully combinational with no latches.

Defaults:
- Every output not listed for a state is 0 in that state.
- `ImmSrc` defaults to 00 and `ALUctrl` to add (000).

## Timing
- State register updates on the `clk` edge. All outputs are combinational from the current state, `Instr`, `EQ` and `MemReady`.
- Reset:
  - `rst` high at an edge → state = FETCH.
  - While `rst` is high, every enable is forced to 0: `MemReq`, `MemWrite`, `IRWrite`, `PCWrite`, `RegWrite`, `Retire`.
  - Select outputs follow their FETCH values during reset.
- Reset mid-operation: any state, including one waiting on memory, returns to FETCH one edge after `rst` is sampled. No write enable pulses during reset cycles.
- Latency with zero-wait memory (`MemReady=1` on the first request cycle), in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, illegal 2.
- Each cycle `MemReq` is held with `MemReady=0` adds exactly one cycle.
- `MemReady` is ignored in states where `MemReq=0`.
- `MemReq` is asserted in the same cycle the state is entered and deasserted in the cycle after `MemReady`.
- beq with `EQ=0`: `PCWrite=0`, so the PC keeps the PC+4 value written in FETCH.

## Structure
- `ctrl_pkg` holds:
  - the state enum
  - opcode constants (`OP_LW`, `OP_SW`, `OP_R`, `OP_I`, `OP_BEQ`)
  - ALUop, ALUctrl, ImmSrc, ResultSrc, ALUsrcA and ALUsrcB encodings
- Sub-module `alu_decoder`: inputs ALUop, funct3, funct7b5, op5; output ALUctrl. It is purely combinational.
- Top level: one state register, one next-state process and one output process.

## Test plan
- **Zero-wait lw**: lw `0x00402083` with `MemReady` tied high.
  - States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - `RegWrite` is high only in cycle 5, with `ResultSrc=01`.
  - `Retire` pulses once.
- **sw with waits**: sw `0x00112223` with `MemReady` low for 3 cycles in MEMWRITE.
  - `MemReq` and `MemWrite` stay high for 4 cycles.
  - Total latency is 7 cycles.
  - `RegWrite` never goes high.
- **R-type decode**:
  - sub `0x40208033` → `ALUctrl=001` in EXECUTER.
  - slt `0x0020A033` → 101.
  - or → 011; and → 010.
  - addi `0x00500093` → 000 with `ALUsrcB=01`.
- **beq both ways**: beq `0x00208463` with `EQ=1` → `PCWrite=1` in BEQ. With `EQ=0` → `PCWrite=0`. Both take 3 cycles.
- **Reset and illegal opcode**:
  - Assert `rst` during the MEMREAD wait → state is FETCH one edge later; no enable is high during reset.
  - Opcode `0x0000007F` → FETCH, DECODE, FETCH, with no `RegWrite` or `MemWrite`.
